// File: rtl/datacache_sram_arbiter.sv
// datacache_sram_arbiter
// Two-port arbiter/sequencer for the single-port data cache SRAM macro.
// Port 0 = core load/store unit, port 1 = refill/writeback engine.
// One request is granted per cycle. The macro is driven combinationally from
// the granted request. Reads are tracked through the fixed macro latency so
// each response returns to the port that issued it.
// Optional build macro: DCACHE_SRAM_ARB_PERF_EN adds three 32-bit perf counters.
module datacache_sram_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WMASKS   = 4,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p0_valid_i,
    output logic                  p0_ready_o,
    input  logic                  p0_we_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    input  logic [NUM_WMASKS-1:0] p0_wmask_i,
    input  logic                  p1_valid_i,
    output logic                  p1_ready_o,
    input  logic                  p1_we_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    input  logic [NUM_WMASKS-1:0] p1_wmask_i,
    input  logic                  p1_lock_i,
    output logic [1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [NUM_WMASKS-1:0] sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_din_o,
    input  logic [DATA_WIDTH-1:0] sram_dout_i
`ifdef DCACHE_SRAM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_conflict_o,
    output logic [31:0]           perf_p0_gnt_o,
    output logic [31:0]           perf_p1_gnt_o
`endif
);

    // Port that was granted most recently (1 after reset so port 0 wins first)
    logic                    last_gnt;
    logic                    gnt0;
    logic                    gnt1;
    logic                    rd_acc;
    logic                    rsp_hit;
    // Read tracking pipeline: valid bit and issuing port per stage
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [READ_LATENCY-1:0] port_pipe;

    // Arbitration: single requester wins, lock forces port 1, else round-robin
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (p0_valid_i && p1_valid_i) begin
                if (p1_lock_i || !last_gnt) gnt1 = 1'b1;
                else                        gnt0 = 1'b1;
            end else begin
                gnt0 = p0_valid_i;
                gnt1 = p1_valid_i;
            end
        end
    end

    assign p0_ready_o = gnt0;
    assign p1_ready_o = gnt1;
    assign rd_acc     = (gnt0 && !p0_we_i) || (gnt1 && !p1_we_i);

    // Macro drive: idle values unless a request is accepted this cycle
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = '0;
        sram_addr_o  = '0;
        sram_din_o   = '0;
        if (gnt0) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~p0_we_i;
            sram_wmask_o = p0_we_i ? p0_wmask_i : '0;
            sram_addr_o  = p0_addr_i;
            sram_din_o   = p0_wdata_i;
        end else if (gnt1) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~p1_we_i;
            sram_wmask_o = p1_we_i ? p1_wmask_i : '0;
            sram_addr_o  = p1_addr_i;
            sram_din_o   = p1_wdata_i;
        end
    end

    // Round-robin pointer moves only when something is accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end

    // Read tracking shift pipeline; never stalls, cleared by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            vld_pipe[0]  <= rd_acc;
            port_pipe[0] <= gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                port_pipe[i] <= port_pipe[i-1];
            end
        end
    end

    // Response: last stage steers macro output to the issuing port; reset
    // in the response cycle suppresses it
    always_comb begin
        rsp_hit     = vld_pipe[READ_LATENCY-1] && !rst_i;
        rsp_valid_o = {rsp_hit && port_pipe[READ_LATENCY-1],
                       rsp_hit && !port_pipe[READ_LATENCY-1]};
        rsp_rdata_o = rsp_hit ? sram_dout_i : '0;
    end

`ifdef DCACHE_SRAM_ARB_PERF_EN
    // Free-running perf counters, wrap modulo 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_conflict_o <= '0;
            perf_p0_gnt_o   <= '0;
            perf_p1_gnt_o   <= '0;
        end else begin
            if (p0_valid_i && p1_valid_i) perf_conflict_o <= perf_conflict_o + 32'd1;
            if (gnt0)                     perf_p0_gnt_o   <= perf_p0_gnt_o + 32'd1;
            if (gnt1)                     perf_p1_gnt_o   <= perf_p1_gnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_datacache_sram_arbiter.sv
// Bench for datacache_sram_arbiter: table-driven vectors from reset plus
// hand-written sequences for alternation, lock, reset mid-flight and
// (when DCACHE_SRAM_ARB_PERF_EN is defined) perf counters.
module tb_datacache_sram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        p0_valid_i, p0_we_i, p1_valid_i, p1_we_i, p1_lock_i;
    logic [10:0] p0_addr_i, p1_addr_i;
    logic [31:0] p0_wdata_i, p1_wdata_i, sram_dout_i;
    logic [3:0]  p0_wmask_i, p1_wmask_i;
    logic        p0_ready_o, p1_ready_o, sram_csb_o, sram_web_o;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_rdata_o, sram_din_o;
    logic [3:0]  sram_wmask_o;
    logic [10:0] sram_addr_o;
`ifdef DCACHE_SRAM_ARB_PERF_EN
    logic [31:0] perf_conflict_o, perf_p0_gnt_o, perf_p1_gnt_o;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    datacache_sram_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o), .p0_we_i(p0_we_i),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i), .p0_wmask_i(p0_wmask_i),
        .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o), .p1_we_i(p1_we_i),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_wmask_i(p1_wmask_i),
        .p1_lock_i(p1_lock_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
        .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
`ifdef DCACHE_SRAM_ARB_PERF_EN
        ,
        .perf_conflict_o(perf_conflict_o), .perf_p0_gnt_o(perf_p0_gnt_o),
        .perf_p1_gnt_o(perf_p1_gnt_o)
`endif
    );

    typedef struct {
        logic        p0v, p0we;
        logic [10:0] p0a;
        logic [31:0] p0d;
        logic [3:0]  p0m;
        logic        p1v, p1we;
        logic [10:0] p1a;
        logic [31:0] p1d;
        logic [3:0]  p1m;
        logic        lock;
        logic [31:0] dout;
        logic        r0, r1, csb, web;
        logic [10:0] addr;
        logic [31:0] din;
        logic [3:0]  wm;
        logic [1:0]  rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        p0_valid_i = 1'b0; p0_we_i = 1'b0; p0_addr_i = '0; p0_wdata_i = '0; p0_wmask_i = '0;
        p1_valid_i = 1'b0; p1_we_i = 1'b0; p1_addr_i = '0; p1_wdata_i = '0; p1_wmask_i = '0;
        p1_lock_i  = 1'b0;
    endtask

    task automatic both_read();
        p0_valid_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 11'h100;
        p1_valid_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 11'h200;
    endtask

    // Leaves the bench at posedge+1 of the first cycle out of reset
    task automatic reset_dut();
        idle();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    initial begin
        idle();
        sram_dout_i = 32'h0BAD_0BAD;
        rst_i = 1'b1;
        // Requests held during reset must not be granted
        p0_valid_i = 1'b1; p1_valid_i = 1'b1;

        //         p0v   p0we  p0a      p0d            p0m      p1v   p1we  p1a      p1d            p1m      lock  dout           r0    r1    csb   web   addr     din            wm       rv     rd
        vecs[0]  = '{1'b1, 1'b0, 11'h010, '0,            '0,      1'b0, 1'b0, '0,      '0,            '0,      1'b0, '0,            1'b1, 1'b0, 1'b0, 1'b1, 11'h010, '0,            '0,      2'b00, '0};
        vecs[1]  = '{1'b1, 1'b0, 11'h020, '0,            '0,      1'b1, 1'b0, 11'h030, '0,            '0,      1'b0, '0,            1'b0, 1'b1, 1'b0, 1'b1, 11'h030, '0,            '0,      2'b00, '0};
        vecs[2]  = '{1'b1, 1'b0, 11'h020, '0,            '0,      1'b1, 1'b0, 11'h031, '0,            '0,      1'b0, '0,            1'b1, 1'b0, 1'b0, 1'b1, 11'h020, '0,            '0,      2'b00, '0};
        vecs[3]  = '{1'b0, 1'b0, '0,      '0,            '0,      1'b1, 1'b1, 11'h7FF, 32'h12345678, 4'b0011, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 11'h7FF, 32'h12345678, 4'b0011, 2'b01, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 11'h040, '0,            '0,      1'b1, 1'b0, 11'h050, '0,            '0,      1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1, 11'h050, '0,            '0,      2'b10, 32'hCAFEF00D};
        vecs[5]  = '{1'b1, 1'b0, 11'h040, '0,            '0,      1'b1, 1'b1, 11'h051, 32'hAAAA5555, 4'b1111, 1'b0, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 11'h040, '0,            '0,      2'b01, 32'h11111111};
        vecs[6]  = '{1'b1, 1'b1, 11'h060, 32'hFFFF0000, 4'b1100, 1'b1, 1'b1, 11'h051, 32'hAAAA5555, 4'b1111, 1'b0, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, 11'h051, 32'hAAAA5555, 4'b1111, 2'b00, '0};
        vecs[7]  = '{1'b1, 1'b1, 11'h060, 32'hFFFF0000, 4'b1100, 1'b0, 1'b0, '0,      '0,            '0,      1'b0, 32'h33333333, 1'b1, 1'b0, 1'b0, 1'b0, 11'h060, 32'hFFFF0000, 4'b1100, 2'b10, 32'h33333333};
        vecs[8]  = '{1'b0, 1'b0, '0,      '0,            '0,      1'b0, 1'b0, '0,      '0,            '0,      1'b0, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b1, '0,      '0,            '0,      2'b01, 32'h44444444};
        vecs[9]  = '{1'b1, 1'b0, 11'h0AA, 32'h99999999, 4'b1111, 1'b0, 1'b0, '0,      '0,            '0,      1'b0, 32'h55555555, 1'b1, 1'b0, 1'b0, 1'b1, 11'h0AA, 32'h99999999, '0,      2'b00, '0};
        vecs[10] = '{1'b0, 1'b0, '0,      '0,            '0,      1'b0, 1'b0, '0,      '0,            '0,      1'b0, 32'h66666666, 1'b0, 1'b0, 1'b1, 1'b1, '0,      '0,            '0,      2'b00, '0};
        vecs[11] = '{1'b0, 1'b0, '0,      '0,            '0,      1'b0, 1'b0, '0,      '0,            '0,      1'b0, 32'h77777777, 1'b0, 1'b0, 1'b1, 1'b1, '0,      '0,            '0,      2'b00, '0};
        vecs[12] = '{1'b0, 1'b0, '0,      '0,            '0,      1'b0, 1'b0, '0,      '0,            '0,      1'b0, 32'h88888888, 1'b0, 1'b0, 1'b1, 1'b1, '0,      '0,            '0,      2'b01, 32'h88888888};

        // Reset state
        @(negedge clk_i);
        chk("rst.ready", {p0_ready_o, p1_ready_o}, 2'b00);
        chk("rst.csb_web", {sram_csb_o, sram_web_o}, 2'b11);
        chk("rst.sram", {sram_addr_o, sram_wmask_o, sram_din_o}, '0);
        chk("rst.rsp", {rsp_valid_o, rsp_rdata_o}, '0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Table-driven vectors, one per cycle
        for (int i = 0; i < 13; i++) begin
            p0_valid_i = vecs[i].p0v; p0_we_i = vecs[i].p0we; p0_addr_i = vecs[i].p0a;
            p0_wdata_i = vecs[i].p0d; p0_wmask_i = vecs[i].p0m;
            p1_valid_i = vecs[i].p1v; p1_we_i = vecs[i].p1we; p1_addr_i = vecs[i].p1a;
            p1_wdata_i = vecs[i].p1d; p1_wmask_i = vecs[i].p1m;
            p1_lock_i  = vecs[i].lock; sram_dout_i = vecs[i].dout;
            @(negedge clk_i);
            chk($sformatf("v%0d.ready", i), {p0_ready_o, p1_ready_o}, {vecs[i].r0, vecs[i].r1});
            chk($sformatf("v%0d.csb_web", i), {sram_csb_o, sram_web_o}, {vecs[i].csb, vecs[i].web});
            chk($sformatf("v%0d.addr", i), sram_addr_o, vecs[i].addr);
            chk($sformatf("v%0d.din", i), sram_din_o, vecs[i].din);
            chk($sformatf("v%0d.wmask", i), sram_wmask_o, vecs[i].wm);
            chk($sformatf("v%0d.rsp_valid", i), rsp_valid_o, vecs[i].rv);
            chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata_o, vecs[i].rd);
            next_cycle();
        end

        // Continuous conflict from reset: grants alternate, responses follow 3 cycles later
        reset_dut();
        both_read();
        for (int k = 0; k < 8; k++) begin
            sram_dout_i = 32'hA000_0000 + k;
            @(negedge clk_i);
            chk($sformatf("alt%0d.ready", k), {p0_ready_o, p1_ready_o},
                (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k >= 3) begin
                chk($sformatf("alt%0d.rsp_valid", k), rsp_valid_o,
                    ((k - 3) % 2 == 0) ? 2'b01 : 2'b10);
                chk($sformatf("alt%0d.rsp_rdata", k), rsp_rdata_o, 32'hA000_0000 + k);
            end else begin
                chk($sformatf("alt%0d.rsp_valid", k), rsp_valid_o, 2'b00);
            end
            next_cycle();
        end

        // Lock holds port 1 for 4 cycles, then port 0 wins
        reset_dut();
        both_read();
        p1_lock_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk($sformatf("lock%0d.ready", k), {p0_ready_o, p1_ready_o}, 2'b01);
            next_cycle();
        end
        p1_lock_i = 1'b0;
        @(negedge clk_i);
        chk("unlock.ready", {p0_ready_o, p1_ready_o}, 2'b10);
        next_cycle();

        // Reads in flight are dropped by a reset pulse
        reset_dut();
        p0_valid_i = 1'b1;
        @(negedge clk_i);
        chk("flight.c0_ready", {p0_ready_o, p1_ready_o}, 2'b10);
        next_cycle();
        idle();
        p1_valid_i = 1'b1; p1_addr_i = 11'h3C3;
        @(negedge clk_i);
        chk("flight.c1_ready", {p0_ready_o, p1_ready_o}, 2'b01);
        next_cycle();
        rst_i = 1'b1;
        p0_valid_i = 1'b1;
        sram_dout_i = 32'h5A5A_5A5A;
        @(negedge clk_i);
        chk("flight.rst_ready", {p0_ready_o, p1_ready_o}, 2'b00);
        chk("flight.rst_csb_web", {sram_csb_o, sram_web_o}, 2'b11);
        chk("flight.rst_sram", {sram_addr_o, sram_wmask_o, sram_din_o}, '0);
        chk("flight.rst_rsp", {rsp_valid_o, rsp_rdata_o}, '0);
        next_cycle();
        rst_i = 1'b0;
        idle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            chk($sformatf("flight.drop%0d", k), {rsp_valid_o, rsp_rdata_o}, '0);
            next_cycle();
        end
        both_read();
        @(negedge clk_i);
        chk("flight.first_conflict", {p0_ready_o, p1_ready_o}, 2'b10);
        next_cycle();

        // Reset in the response cycle suppresses the response
        reset_dut();
        p0_valid_i = 1'b1;
        next_cycle();
        idle();
        next_cycle();
        next_cycle();
        rst_i = 1'b1;
        sram_dout_i = 32'h7777_0000;
        @(negedge clk_i);
        chk("supp.rsp", {rsp_valid_o, rsp_rdata_o}, '0);
        next_cycle();
        rst_i = 1'b0;

`ifdef DCACHE_SRAM_ARB_PERF_EN
        // Ten cycles of conflict: counters 10 / 5 / 5
        reset_dut();
        both_read();
        for (int k = 0; k < 10; k++) next_cycle();
        idle();
        @(negedge clk_i);
        chk("perf.conflict", perf_conflict_o, 32'd10);
        chk("perf.p0", perf_p0_gnt_o, 32'd5);
        chk("perf.p1", perf_p1_gnt_o, 32'd5);
        next_cycle();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
